// File: rtl/ixc_skid_reg_48_if.sv
// Valid/ready bundle for the 48-bit skid slice.
// Master drives beats in and takes them out; slave is the slice.
interface ixc_skid_reg_48_if #(
  parameter int WIDTH = 48
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] L_data;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  L_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output L_data,
    input  out_ready
  );
endinterface

// File: rtl/ixc_skid_reg_48.sv
// Two-entry skid register slice: registered data, valid and ready.
// Main entry drives L_data; skid entry absorbs one beat of backpressure.
module ixc_skid_reg_48 #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ixc_skid_reg_48_if.slave bus,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             rdy_q;
  logic             vld_q;
  logic             acc;
  logic             snd;

  assign acc = bus.in_valid & rdy_q;
  assign snd = vld_q & bus.out_ready;

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.L_data    = main_q;
  assign occupancy     = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = bus.in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && snd) begin
          main_d = bus.in_data;
        end else if (acc) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (snd) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (snd) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      beat_cnt <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      // ready and valid follow the next state so neither is combinational
      rdy_q   <= (state_d != FULL);
      vld_q   <= (state_d == ONE) || (state_d == FULL);
      if (acc) beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ixc_skid_reg_48.sv
// Directed bench for ixc_skid_reg_48 with a FIFO scoreboard.
// Inputs change and outputs are sampled around the falling edge.
module tb_ixc_skid_reg_48;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] beat_cnt;

  int n_assert;
  int n_fail;

  ixc_skid_reg_48_if #(.WIDTH(48)) bus ();

  ixc_skid_reg_48 #(.WIDTH(48), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .flush     (flush),
    .occupancy (occupancy),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " L_data"}, 64'(bus.L_data), 64'd0);
    chk({tag, " occ"}, 64'(occupancy), 64'd0);
    chk({tag, " cnt"}, 64'(beat_cnt), 64'd0);
  endtask

  logic [47:0] q[$];
  logic [47:0] d;
  logic [47:0] exp_d;
  logic [15:0] cnt_save;
  int          sent;
  int          cyc;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy after release", 64'(bus.in_ready), 64'd1);

    // streaming: 8 beats at full rate, 1-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_data = 48'(i);
      @(negedge clk);
      chk("stream data", 64'(bus.L_data), 64'(i));
      chk("stream valid", 64'(bus.out_valid), 64'd1);
      chk("stream rdy", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream cnt", 64'(beat_cnt), 64'd8);
    chk("stream idle valid", 64'(bus.out_valid), 64'd0);
    chk("stream hold data", 64'(bus.L_data), 64'h8);

    // backpressure fill
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'hAAAA_AAAA_AAAA;
    @(negedge clk);
    chk("bp occ1", 64'(occupancy), 64'd1);
    chk("bp data1", 64'(bus.L_data), 64'hAAAA_AAAA_AAAA);
    bus.in_data = 48'h5555_5555_5555;
    @(negedge clk);
    chk("bp occ2", 64'(occupancy), 64'd2);
    chk("bp rdy0", 64'(bus.in_ready), 64'd0);
    bus.in_data = 48'h1234_5678_9ABC;
    @(negedge clk);
    chk("bp hold occ", 64'(occupancy), 64'd2);
    chk("bp hold data", 64'(bus.L_data), 64'hAAAA_AAAA_AAAA);
    chk("bp cnt", 64'(beat_cnt), 64'd10);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp out2", 64'(bus.L_data), 64'h5555_5555_5555);
    chk("bp rdy1", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    chk("bp out3", 64'(bus.L_data), 64'h1234_5678_9ABC);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp cnt3", 64'(beat_cnt), 64'd11);
    chk("bp drained", 64'(occupancy), 64'd0);

    // alternating out_ready with continuous in_valid, scoreboarded
    sent = 0;
    cyc  = 0;
    d = {16'($urandom()), 32'($urandom())};
    bus.in_data = d;
    while (sent < 100 && cyc < 1000) begin
      bus.in_valid  = (sent + q.size()) < 100;
      bus.out_ready = cyc[0];
      #1;
      if (occupancy > 2'd2) chk("sb occ", 64'(occupancy), 64'd2);
      if (bus.out_valid && bus.out_ready) begin
        exp_d = q.pop_front();
        chk("sb data", 64'(bus.L_data), 64'(exp_d));
        sent++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(d);
        d = {16'($urandom()), 32'($urandom())};
      end
      @(negedge clk);
      bus.in_data = d;
      cyc++;
    end
    chk("sb sent", 64'(sent), 64'd100);
    chk("sb empty", 64'(q.size()), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("sb idle occ", 64'(occupancy), 64'd0);

    // flush while FULL with a beat offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'hC1;
    @(negedge clk);
    bus.in_data = 48'hC2;
    @(negedge clk);
    chk("fl full", 64'(occupancy), 64'd2);
    cnt_save = beat_cnt;
    bus.in_data = 48'hC3;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl valid", 64'(bus.out_valid), 64'd0);
    chk("fl occ", 64'(occupancy), 64'd0);
    chk("fl rdy", 64'(bus.in_ready), 64'd1);
    chk("fl data", 64'(bus.L_data), 64'd0);
    chk("fl cnt", 64'(beat_cnt), 64'(cnt_save));

    // counter wrap
    force dut.beat_cnt = 16'hFFFE;
    #1;
    release dut.beat_cnt;
    #1;
    chk("wrap preset", 64'(beat_cnt), 64'hFFFE);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 48'(16'hD0 + i);
      @(negedge clk);
      if (i == 1) chk("wrap zero", 64'(beat_cnt), 64'h0000);
    end
    bus.in_valid = 1'b0;
    chk("wrap cnt", 64'(beat_cnt), 64'h0001);
    chk("wrap last", 64'(bus.L_data), 64'hD2);

    // async reset mid-cycle while FULL
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 48'hE1;
    @(negedge clk);
    bus.in_data = 48'hE2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ar full", 64'(occupancy), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar no stale", 64'(bus.out_valid), 64'd0);
    end
    chk("ar data", 64'(bus.L_data), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ixc_skid_reg_48.md
Name: ixc_skid_reg_48

Overview:
- 48-bit valid/ready register slice with a two-entry skid buffer.
- Sits directly upstream of the 48-bit continuous-assign stage in the template library; its registered output L_data drives that stage's R input.
- Breaks combinational paths on both data/valid and ready, so the emulator sees only flop-to-flop timing across the slice boundary.
- Full throughput (one beat per clock) is sustained.

Parameters:
- WIDTH, 48, payload width in bits; the bench covers 48 only.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  slice can accept a beat; registered.
- out_valid  output  1  L_data holds a valid beat; registered.
- L_data  output  WIDTH  registered payload to the downstream assign stage.
- out_ready  input  1  downstream accepts.
- flush  input  1  synchronous clear of both entries.
- occupancy  output  2  entries held: 0, 1 or 2.
- beat_cnt  output  CNT_W  count of beats accepted at the input.

Behaviour:
- Reset (rst_n low, asynchronous): in_ready=0, out_valid=0, L_data=0, occupancy=0, beat_cnt=0, skid entry cleared.
- First clk edge after rst_n rises: in_ready=1.
- Reset mid-transfer discards all held beats; nothing is replayed.
- Storage: a main register (drives L_data/out_valid) and a skid register.
- FSM states:
  - EMPTY (occ 0)
  - ONE (occ 1, main valid)
  - FULL (occ 2, main and skid valid).
- Handshake: accept = in_valid & in_ready; send = out_valid & out_ready.
  - in_valid may assert regardless of in_ready.
  - in_data must stay stable while in_valid=1 and in_ready=0; the slice does not check this.
- Transitions:
  - EMPTY: accept -> main<=in_data, ONE.
  - ONE, accept & send -> main<=in_data, stay ONE.
  - ONE, accept & !send -> skid<=in_data, FULL, in_ready<=0.
  - ONE, send & !accept -> EMPTY.
  - FULL: accept is impossible (in_ready=0). On send -> main<=skid, ONE, in_ready<=1.
  - FULL, !send: hold everything.
- Latency: a beat accepted at edge N appears on L_data/out_valid after edge N, when the path is empty.
- Ordering: strict FIFO; no beat dropped or duplicated.
- in_ready = (occupancy < 2), registered, so it is never combinational from out_ready.
- L_data holds its last value when out_valid=0. No zeroing except at reset and flush.
- flush (synchronous, highest priority after reset):
  - next state EMPTY, out_valid=0, in_ready=1, L_data=0.
  - An accept in the same cycle is discarded and is not counted.
- beat_cnt:
  - increments on each counted accept.
  - wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
  - not cleared by flush.
- occupancy always equals state encoding.
- Illegal state (e.g. upset) recovers to EMPTY on the next edge.

Test Plan:
- Reset then streaming:
  - Stimulus: hold rst_n=0 for 3 cycles, release, out_ready=1, drive 8 back-to-back beats 0x000000000001..0x000000000008.
  - Required response: L_data shows them in order, one per cycle, with 1-cycle latency.
  - in_ready stays 1; beat_cnt=8.
- Backpressure fill:
  - Stimulus: out_ready=0, send 0xAAAA_AAAA_AAAA then 0x5555_5555_5555.
  - Required response: occupancy=2, in_ready=0 on the cycle after the second accept; a third beat held on in_valid is not taken.
  - Then raise out_ready: outputs 0xAAAA..., 0x5555..., then the third beat, in order.
- Simultaneous accept/send in ONE:
  - Stimulus: alternate out_ready with continuous in_valid.
  - Required response: occupancy never exceeds 2, no loss or duplication; a scoreboard matches 100 random 48-bit beats.
- Flush in FULL with concurrent in_valid=1:
  - Required response: next cycle out_valid=0, occupancy=0, in_ready=1, L_data=0; beat_cnt unchanged.
- Counter wrap:
  - Stimulus: force beat_cnt to 0xFFFE, accept 3 beats.
  - Required response: beat_cnt reads 0x0001.
- Async reset mid-operation:
  - Stimulus: drop rst_n between clock edges while in FULL.
  - Required response: outputs go to reset values immediately, without waiting for a clk edge; no stale beats appear after release.
